// File: rtl/ram_request_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port among NUM_CLIENTS requesters.
// Latency: req sampled in IDLE -> mem_req next cycle -> cli_ack one cycle after mem_done; size 0 acks next cycle.
// Backpressure: one transaction outstanding; clients hold req until cli_ack. RAM_ARB_WATCHDOG_EN adds a WAIT timeout.
module ram_request_arbiter #(
    parameter int NUM_CLIENTS    = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        cli_req,
    input  logic [NUM_CLIENTS-1:0]        cli_we,
    input  logic [2*NUM_CLIENTS-1:0]      cli_size,
    input  logic [ADDR_W*NUM_CLIENTS-1:0] cli_addr,
    input  logic [DATA_W*NUM_CLIENTS-1:0] cli_wdata,
    output logic [NUM_CLIENTS-1:0]        cli_ack,
    output logic                          cli_err,
    output logic [DATA_W-1:0]             cli_rdata,
    output logic [$clog2(NUM_CLIENTS)-1:0] grant_id,
    output logic                          busy,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [1:0]                    mem_size,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_done,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int GW = $clog2(NUM_CLIENTS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     grant_id_q, grant_id_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef RAM_ARB_WATCHDOG_EN
    logic [15:0]       wd_cnt_q, wd_cnt_d;
    logic              err_q, err_d;
`endif

    logic              pick_vld;
    logic [GW-1:0]     pick_idx;
    logic [GW:0]       cand;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // First requester found scanning upward from rr_ptr, wrapping at NUM_CLIENTS.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (cand >= (GW+1)'(NUM_CLIENTS)) begin
                cand = cand - (GW+1)'(NUM_CLIENTS);
            end
            if (!pick_vld && cli_req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        sel_we    = cli_we[pick_idx];
        sel_size  = cli_size[2*int'(pick_idx) +: 2];
        sel_addr  = cli_addr[ADDR_W*int'(pick_idx) +: ADDR_W];
        sel_wdata = cli_wdata[DATA_W*int'(pick_idx) +: DATA_W];
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef RAM_ARB_WATCHDOG_EN
        wd_cnt_d   = wd_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_id_d = pick_idx;
                    we_d       = sel_we;
                    size_d     = sel_size;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
`ifdef RAM_ARB_WATCHDOG_EN
                    err_d      = 1'b0;
`endif
                    // A size-0 request has nothing to move; acknowledge it without touching memory.
                    state_d    = (sel_size == 2'd0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
`ifdef RAM_ARB_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
                state_d  = WAIT;
            end
            WAIT: begin
                if (mem_done) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
`ifdef RAM_ARB_WATCHDOG_EN
                else if (wd_cnt_q + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
                else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                rr_ptr_d = (grant_id_q == GW'(NUM_CLIENTS-1)) ? '0 : grant_id_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef RAM_ARB_WATCHDOG_EN
            wd_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            we_q       <= we_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
`ifdef RAM_ARB_WATCHDOG_EN
            wd_cnt_q   <= wd_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        cli_ack = '0;
        if (state_q == RESP) begin
            cli_ack[grant_id_q] = 1'b1;
        end
    end

`ifdef RAM_ARB_WATCHDOG_EN
    assign cli_err = (state_q == RESP) && err_q;
`else
    assign cli_err = 1'b0;
`endif

    assign cli_rdata = rdata_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != IDLE);
    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
